// File: rtl/flash_pkg.sv
// flash_pkg: shared types and constants for the W25Q flash read sequencer.
package flash_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_A2, S_A1, S_A0, S_DSH, S_DRD, S_OUT, S_FIN, S_GAP
    } fr_state_t;
    localparam logic [7:0] OP_READ       = 8'h03;
    localparam logic [7:0] OP_RDSR1      = 8'h05;
    localparam logic [7:0] OP_RELEASE_PD = 8'hAB;
    localparam int TIMEOUT_DEF = 255;
    function automatic logic is_bus(fr_state_t s);
        return s inside {S_CMD, S_A2, S_A1, S_A0, S_DSH, S_DRD};
    endfunction
endpackage

// File: rtl/flash_read_seq_if.sv
// flash_read_seq_if: Wishbone byte port between the sequencer and spi_master.
interface flash_read_seq_if;
    logic       cyc;
    logic       stb;
    logic       we;
    logic [7:0] dat_w;
    logic [7:0] dat_r;
    logic       ack;
    modport master (output cyc, stb, we, dat_w, input dat_r, ack);
    modport slave  (input cyc, stb, we, dat_w, output dat_r, ack);
endinterface

// File: rtl/wb_byte_master.sv
// wb_byte_master: single-byte Wishbone cycle engine with an ack timeout.
module wb_byte_master import flash_pkg::*; #(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       we,
    input  logic [7:0] wdata,
    input  logic       ack,
    input  logic [7:0] bus_rdata,
    output logic       busy,
    output logic       bus_we,
    output logic [7:0] bus_wdata,
    output logic [7:0] rdata,
    output logic       ok,
    output logic       timeout
);
    logic [7:0] wait_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            bus_we    <= 1'b0;
            bus_wdata <= '0;
            wait_cnt  <= '0;
        end else if (go) begin
            busy      <= 1'b1;
            bus_we    <= we;
            bus_wdata <= wdata;
            wait_cnt  <= '0;
        end else if (busy) begin
            if (ack || timeout) busy <= 1'b0;
            else wait_cnt <= wait_cnt + 8'd1;
        end
    end
    // busy doubles as STB; ok/timeout are same-cycle so the caller reacts on the ack edge
    assign ok      = busy && ack;
    assign timeout = busy && !ack && wait_cnt == 8'(TIMEOUT - 1);
    assign rdata   = bus_rdata;
endmodule

// File: rtl/flash_read_seq.sv
// flash_read_seq: turns "read N bytes at A" into W25Q READ byte cycles on Wishbone
// and streams the returned bytes out on a valid/ready port.
module flash_read_seq import flash_pkg::*; #(
    parameter logic [7:0] READ_CMD   = OP_READ,
    parameter logic [7:0] DUMMY_BYTE = 8'h00,
    parameter int         TIMEOUT    = TIMEOUT_DEF
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_len,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic [7:0]  byte_data,
    output logic        done,
    output logic        err,
    flash_read_seq_if.master wb
);
    fr_state_t   state, next;
    logic [23:0] addr;
    logic [15:0] remaining;
    logic        go, cyc, accept;
    logic        go_d, cyc_d, done_d;
    logic [7:0]  wr_data, byte_data_d;
    logic        wr_we;
    logic        busy, bus_we, ok, timeout;
    logic [7:0]  bus_wdata, rdata;

    wb_byte_master #(.TIMEOUT(TIMEOUT)) u_wbm (
        .clk       (CLK_I),
        .rst       (RST_I),
        .go        (go),
        .we        (wr_we),
        .wdata     (wr_data),
        .ack       (wb.ack),
        .bus_rdata (wb.dat_r),
        .busy      (busy),
        .bus_we    (bus_we),
        .bus_wdata (bus_wdata),
        .rdata     (rdata),
        .ok        (ok),
        .timeout   (timeout)
    );

    assign wb.cyc   = cyc;
    assign wb.stb   = busy;
    assign wb.we    = bus_we;
    assign wb.dat_w = bus_wdata;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state      <= S_IDLE;
            go         <= 1'b0;
            cyc        <= 1'b0;
            req_ready  <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            addr       <= '0;
            remaining  <= '0;
        end else begin
            state      <= next;
            go         <= go_d;
            cyc        <= cyc_d;
            req_ready  <= next == S_IDLE;
            done       <= done_d;
            err        <= timeout;
            byte_valid <= next == S_OUT;
            byte_data  <= byte_data_d;
            if (accept && req_len != '0) begin
                addr      <= req_addr;
                remaining <= req_len;
            end else if (state == S_OUT && byte_ready) begin
                remaining <= remaining - 16'd1;
            end
        end
    end

    always_comb begin
        next = state;
        case (state)
            S_IDLE:  if (req_valid && req_len != '0) next = S_CMD;
            S_CMD:   if (ok) next = S_A2;
            S_A2:    if (ok) next = S_A1;
            S_A1:    if (ok) next = S_A0;
            S_A0:    if (ok) next = S_DSH;
            S_DSH:   if (ok) next = S_DRD;
            S_DRD:   if (ok) next = S_OUT;
            S_OUT:   if (byte_ready) next = (remaining == 16'd1) ? S_FIN : S_DSH;
            S_FIN:   next = S_GAP;
            default: next = S_IDLE;
        endcase
        if (timeout) next = S_GAP;
    end

    // go is registered on state entry, so STB rises one cycle after the state is entered
    always_comb begin
        accept      = state == S_IDLE && req_valid;
        go_d        = next != state && is_bus(next);
        cyc_d       = is_bus(next) || next == S_OUT;
        done_d      = (state == S_OUT && next == S_FIN) || (accept && req_len == '0);
        byte_data_d = (state == S_DRD && ok) ? rdata : byte_data;
        wr_we       = state != S_DRD;
        wr_data     = state == S_CMD ? READ_CMD :
                      state == S_A2  ? addr[23:16] :
                      state == S_A1  ? addr[15:8] :
                      state == S_A0  ? addr[7:0] : DUMMY_BYTE;
    end
endmodule

// File: tb/tb_flash_read_seq.sv
// tb_flash_read_seq: directed bench with a Wishbone slave model and an event monitor.
module tb_flash_read_seq;
    logic        clk, rst;
    logic        req_valid, req_ready, byte_valid, byte_ready, done, err;
    logic [23:0] req_addr;
    logic [15:0] req_len;
    logic [7:0]  byte_data;
    int checks = 0, failures = 0;

    flash_read_seq_if wb();

    flash_read_seq dut (
        .CLK_I(clk), .RST_I(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
        .done(done), .err(err), .wb(wb)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    logic [7:0] rd_q[$], wr_log[$], rx_q[$];
    int ack_delay = 3, no_ack_txn = -1, txn = 0;
    int cyc_n = 0, stb_rise_cnt = 0, last_stb_rise = 0, cyc_rise_cnt = 0;
    int low_run = 0, low_gap = 0, done_cnt = 0, done_cyc_bad = 0;
    int err_cnt = 0, err_at = 0, acc_cnt = 0;
    logic err_cyc, p_stb = 0, p_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qget(input logic [7:0] q[$], input int i);
        return (i < q.size()) ? {24'h0, q[i]} : 32'hDEAD;
    endfunction

    // Slave: acks after ack_delay cycles of STB, logs writes, serves reads from rd_q
    initial begin
        int wait_n = 0;
        wb.ack = 0;
        wb.dat_r = 0;
        forever begin
            @(negedge clk);
            if (wb.ack) begin
                wb.ack = 0;
                wait_n = 0;
            end else if (wb.stb && txn != no_ack_txn) begin
                wait_n++;
                if (wait_n >= ack_delay) begin
                    wb.ack = 1;
                    wait_n = 0;
                    txn++;
                    if (wb.we) wr_log.push_back(wb.dat_w);
                    else wb.dat_r = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hEE;
                end
            end else wait_n = 0;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc_n++;
            if (wb.stb && !p_stb) begin stb_rise_cnt++; last_stb_rise = cyc_n; end
            if (wb.cyc && !p_cyc) begin cyc_rise_cnt++; low_gap = low_run; end
            low_run = wb.cyc ? 0 : low_run + 1;
            if (done) begin done_cnt++; if (wb.cyc) done_cyc_bad++; end
            if (err) begin err_cnt++; err_at = cyc_n; err_cyc = wb.cyc; end
            if (byte_valid && byte_ready) rx_q.push_back(byte_data);
            if (req_valid && req_ready) acc_cnt++;
            p_stb = wb.stb;
            p_cyc = wb.cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic do_req(input logic [23:0] a, input logic [15:0] n);
        int k = 0;
        while (!req_ready && k < 100) begin @(posedge clk); #1; k++; end
        if (!req_ready) check("req_ready_wait", req_ready, 1);
        req_addr = a; req_len = n; req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic wait_done(input int prev, input int lim);
        int k = 0;
        while (done_cnt <= prev && k < lim) begin @(negedge clk); #1; k++; end
        if (done_cnt <= prev) check("done_wait", done_cnt, prev + 1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cyc"}, wb.cyc, 0);
        check({tag, "_stb"}, wb.stb, 0);
        check({tag, "_we"}, wb.we, 0);
        check({tag, "_dat"}, wb.dat_w, 0);
        check({tag, "_bdata"}, byte_data, 0);
        check({tag, "_bvalid"}, byte_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_rdy"}, req_ready, 1);
    endtask

    logic [7:0] exp1 [6] = '{8'h03, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00};

    initial begin
        int c0, d0, s0, e0, a0, k, bad;
        rst = 1; req_valid = 0; req_addr = 0; req_len = 0; byte_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        rst = 0;
        repeat (2) @(posedge clk);
        #1;

        // two-byte read at 0x012345
        txn = 0; wr_log.delete(); rx_q.delete(); rd_q = '{8'hA5, 8'h5A};
        c0 = cyc_rise_cnt; d0 = done_cnt;
        do_req(24'h012345, 16'd2);
        @(negedge clk); #1;
        check("lat_cyc", wb.cyc, 1);
        check("lat_stb", wb.stb, 0);
        check("lat_rdy", req_ready, 0);
        @(negedge clk); #1;
        check("cmd_stb", wb.stb, 1);
        check("cmd_we", wb.we, 1);
        check("cmd_dat", wb.dat_w, 8'h03);
        wait_done(d0, 300);
        check("t1_rdy_fin", req_ready, 0);
        @(negedge clk); #1;
        check("t1_rdy_gap", req_ready, 0);
        @(negedge clk); #1;
        check("t1_rdy_idle", req_ready, 1);
        check("t1_nwr", wr_log.size(), 6);
        for (int i = 0; i < 6; i++) check("t1_wr", qget(wr_log, i), exp1[i]);
        check("t1_nrx", rx_q.size(), 2);
        check("t1_rx0", qget(rx_q, 0), 8'hA5);
        check("t1_rx1", qget(rx_q, 1), 8'h5A);
        check("t1_cyc_rises", cyc_rise_cnt - c0, 1);
        check("t1_done_cnt", done_cnt - d0, 1);

        // zero length: done only, no bus activity
        d0 = done_cnt; s0 = stb_rise_cnt; c0 = cyc_rise_cnt;
        do_req(24'h000500, 16'd0);
        @(negedge clk); #1;
        check("len0_done", done, 1);
        check("len0_rdy", req_ready, 1);
        repeat (5) @(negedge clk);
        #1;
        check("len0_cyc", cyc_rise_cnt - c0, 0);
        check("len0_stb", stb_rise_cnt - s0, 0);
        check("len0_done_cnt", done_cnt - d0, 1);

        // backpressure on the first of three bytes
        rx_q.delete(); rd_q = '{8'h11, 8'h22, 8'h33}; byte_ready = 0; d0 = done_cnt;
        do_req(24'h000100, 16'd3);
        k = 0;
        while (!byte_valid && k < 300) begin @(negedge clk); #1; k++; end
        check("stall_bv", byte_valid, 1);
        s0 = stb_rise_cnt; bad = 0;
        repeat (20) begin
            @(negedge clk); #1;
            if (wb.stb || !wb.cyc || !byte_valid) bad++;
        end
        check("stall_bad", bad, 0);
        check("stall_stb", stb_rise_cnt - s0, 0);
        @(posedge clk); #1;
        byte_ready = 1;
        wait_done(d0, 300);
        check("stall_nrx", rx_q.size(), 3);
        check("stall_rx0", qget(rx_q, 0), 8'h11);
        check("stall_rx1", qget(rx_q, 1), 8'h22);
        check("stall_rx2", qget(rx_q, 2), 8'h33);
        repeat (3) @(negedge clk);
        #1;

        // slave never acks the A1 byte
        wr_log.delete(); txn = 0; no_ack_txn = 2; e0 = err_cnt; d0 = done_cnt;
        do_req(24'hABCDEF, 16'd1);
        k = 0;
        while (err_cnt == e0 && k < 600) begin @(negedge clk); #1; k++; end
        check("to_seen", err_cnt - e0, 1);
        check("to_lat", err_at - last_stb_rise, 255);
        check("to_cyc", err_cyc, 0);
        check("to_stb", wb.stb, 0);
        check("to_bv", byte_valid, 0);
        check("to_rdy_gap", req_ready, 0);
        @(negedge clk); #1;
        check("to_rdy_idle", req_ready, 1);
        check("to_err_pulse", err, 0);
        check("to_nodone", done_cnt - d0, 0);
        check("to_nwr", wr_log.size(), 2);
        no_ack_txn = -1;
        repeat (3) @(negedge clk);
        #1;

        // reset during the read of byte 5 of 10
        rx_q.delete(); rd_q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59};
        do_req(24'h001000, 16'd10);
        k = 0;
        while (!(rx_q.size() == 4 && wb.stb && !wb.we) && k < 1000) begin @(negedge clk); #1; k++; end
        check("mid_found", rx_q.size() == 4 && wb.stb && !wb.we, 1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        check_reset("mid");
        rst = 0;
        repeat (3) @(negedge clk);
        #1;
        rd_q.delete(); rd_q.push_back(8'hC3); wr_log.delete(); rx_q.delete(); d0 = done_cnt;
        do_req(24'h000200, 16'd1);
        wait_done(d0, 300);
        check("post_rx", qget(rx_q, 0), 8'hC3);
        check("post_nrx", rx_q.size(), 1);
        check("post_wr0", qget(wr_log, 0), 8'h03);
        check("post_wr2", qget(wr_log, 2), 8'h02);
        repeat (3) @(negedge clk);
        #1;

        // back-to-back requests with req_valid held high
        rd_q = '{8'h71, 8'h72}; rx_q.delete(); wr_log.delete(); a0 = acc_cnt; d0 = done_cnt;
        req_addr = 24'h0A0B0C; req_len = 16'd1; req_valid = 1;
        k = 0;
        while (acc_cnt < a0 + 2 && k < 500) begin @(negedge clk); #1; k++; end
        check("b2b_acc", acc_cnt - a0, 2);
        @(posedge clk); #1;
        req_valid = 0;
        wait_done(d0 + 1, 300);
        check("b2b_done", done_cnt - d0, 2);
        check("b2b_gap", low_gap, 3);
        check("b2b_nwr", wr_log.size(), 10);
        check("b2b_wr5", qget(wr_log, 5), 8'h03);
        check("b2b_wr8", qget(wr_log, 8), 8'h0C);
        check("b2b_rx0", qget(rx_q, 0), 8'h71);
        check("b2b_rx1", qget(rx_q, 1), 8'h72);
        check("done_cyc_overlap", done_cyc_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/flash_read_seq.md
# flash_read_seq

Sequencer that turns a "read N bytes from flash address A" request into the byte-level Wishbone transactions `spi_master` needs to run a W25Q32 READ (0x03) command. It emits the returned data as a valid/ready byte stream. It sits between boot/config logic and `spi_master`, and is the only Wishbone master on that port. `spi_master` slave semantics, decided for this pairing:
- CS is asserted while `CYC_I` is high.
- A write cycle shifts `DAT_I` out and captures MISO, and acks when the byte completes.
- A read cycle returns the last captured byte.

## Interface
Parameters:
- `READ_CMD`, 8'h03, opcode sent first.
- `DUMMY_BYTE`, 8'h00, MOSI byte sent during data phase.
- `TIMEOUT`, 255, max cycles `STB_O` waits for `ACK_I` (8-bit counter).

Ports:
- `CLK_I`  in  1  system clock.
- `RST_I`  in  1  reset. One clock; reset is synchronous and active-high.
- `req_valid`  in  1  request strobe.
- `req_ready`  out  1  high only in IDLE.
- `req_addr`  in  24  flash byte address.
- `req_len`  in  16  byte count; 0 = no bus activity.
- `byte_valid`  out  1  `byte_data` holds a flash byte.
- `byte_ready`  in  1  consumer accepts byte.
- `byte_data`  out  8  returned byte.
- `done`  out  1  one-cycle pulse, request finished OK.
- `err`  out  1  one-cycle pulse, Wishbone timeout.
- `CYC_O`, `STB_O`, `WE_O`  out  1  Wishbone master controls.
- `DAT_O`  out  8  write data.
- `DAT_I`  in  8  read data.
- `ACK_I`  in  1  slave ack.

## Operation
- States:
  - IDLE → CMD → A2 → A1 → A0 → DSH → DRD → OUT → (DSH | FIN).
  - FIN → GAP → IDLE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid` with `req_len`≠0: latch addr/len, assert `CYC_O`, go CMD.
  - On `req_len`=0: pulse `done` next cycle and stay IDLE.
- CMD/A2/A1/A0:
  - Write cycle (`WE_O`=1) with `READ_CMD`, then addr[23:16], addr[15:8], addr[7:0].
  - Advance on `ACK_I`.
- DSH: write cycle with `DUMMY_BYTE`; on ack → DRD.
- DRD: read cycle (`WE_O`=0); on ack latch `DAT_I` into `byte_data` → OUT.
- OUT:
  - `byte_valid`=1 until `byte_ready`.
  - On handshake, decrement remaining count: →DSH if nonzero, else →FIN.
  - `CYC_O` stays high, so CS is held while the SPI clock is paused under backpressure.
- FIN: drop `CYC_O`, pulse `done` → GAP.
- GAP: one cycle with `CYC_O` low (CS deselect time) → IDLE.
- Address is not incremented by this block; the flash auto-increments.
- Remaining count is 16-bit and is loaded from `req_len`, so the maximum is 65535 bytes.
- Timeout:
  - Counter clears on each new `STB_O` assertion and increments while `STB_O`=1 && !`ACK_I`.
  - At `TIMEOUT`: drop `CYC_O`/`STB_O`, clear `byte_valid`, pulse `err`, go GAP. No `done` is pulsed.

## Timing
- Reset values:
  - `CYC_O`=`STB_O`=`WE_O`=0.
  - `DAT_O`=0, `byte_data`=0.
  - `byte_valid`=`done`=`err`=0.
  - `req_ready`=1; state=IDLE.
- Reset mid-transfer takes effect at the next edge with the same values; CS releases because `CYC_O` falls.
- All outputs are registered.
- `STB_O` rises the cycle after state entry and is held with stable `DAT_O`/`WE_O` until `ACK_I`.
- `STB_O` falls the cycle after the ack is sampled.
- An ack arriving while `STB_O`=0 is ignored.
- Latency, request accept → `CYC_O` high: 1 cycle.
- `byte_valid` rises 1 cycle after the DRD ack.
- `done` is asserted the cycle after the last byte handshake. `CYC_O` falls that same cycle.
- `req_ready` returns 2 cycles after `done` (FIN, GAP).
- `byte_valid` && `byte_ready` in the same cycle counts as one transfer; `byte_valid` falls the next cycle.

## Structure
- `flash_pkg`:
  - State enum (`fr_state_t`).
  - W25Q opcodes: READ 0x03, RDSR1 0x05, RELEASE_PD 0xAB.
  - `TIMEOUT` default.
- Sub-module `wb_byte_master`: one Wishbone single-cycle engine with inputs go/we/wdata and outputs busy/rdata/ok/timeout, reused for every byte. The FSM stays in `flash_read_seq`.

## Test plan
- Read at 0x012345, len=2; slave acks after 3 cycles and returns 0xA5, 0x5A.
  - Write sequence 0x03, 0x01, 0x23, 0x45, 0x00.
  - Read returns 0xA5; then 0x00 write, read returns 0x5A.
  - `done` pulses once; `CYC_O` is continuously high from accept to FIN.
- `req_len`=0: no `CYC_O` activity; `done` 1 cycle after accept.
- `byte_ready` held low 20 cycles on the first of 3 bytes:
  - No `STB_O` during the stall.
  - `CYC_O` stays high.
  - All 3 bytes are delivered in order.
- Slave never acks the A1 byte: `err` at cycle `TIMEOUT` after `STB_O` rises, `CYC_O` low, back to IDLE 1 cycle later, no `done`.
- `RST_I` asserted during the DRD of byte 5 of 10: every output at its reset value next edge; a fresh request then completes normally.
- Back-to-back requests: the second `req_valid` is held high; `CYC_O` shows at least a 1-cycle low gap and the second sequence restarts with 0x03.
